// File: rtl/axi_ad9963_tx_burst_ctrl.sv
// -----------------------------------------------------------------------------
// axi_ad9963_tx_burst_ctrl
//
// Burst sequencer for the AD9963 TX path. Once configured and armed, it waits
// for a sync trigger. It then passes bursts of cfg_burst_len valid samples to
// the I/Q DMA channels. Bursts are separated by cfg_gap_len idle valid samples.
// The sequence repeats cfg_repeat times, or forever when cfg_repeat is 0.
//
// Ports
//   dac_clk        : DAC clock, the only clock of this block
//   dac_rst        : synchronous active-high reset
//   cfg_start      : pulse; latches cfg_* and arms the sequencer (IDLE only)
//   cfg_stop       : pulse; aborts any activity, wins over cfg_start
//   cfg_burst_len  : samples per burst (0 = start request ignored)
//   cfg_gap_len    : valid samples idled between bursts (0 = back-to-back)
//   cfg_repeat     : bursts per run, 0 = infinite
//   dac_sync       : trigger that releases ARMED into the first burst
//   dac_valid_in   : sample strobe from the TX core
//   dac_dunf       : DMA underflow
//   dac_valid_i/q  : gated sample strobes, combinational, only while in RUN
//   dac_tx_en      : registered "state is RUN"; low makes the datapath send zero
//   busy           : sequencer not IDLE
//   done           : one-cycle pulse after the final burst of a finite run
//   unf_err        : sticky underflow seen during RUN
//   burst_cnt      : bursts completed in the current run
// -----------------------------------------------------------------------------
module axi_ad9963_tx_burst_ctrl #(
    parameter int CNT_WIDTH = 16,
    parameter int REP_WIDTH = 8
) (
    input  logic                 dac_clk,
    input  logic                 dac_rst,
    input  logic                 cfg_start,
    input  logic                 cfg_stop,
    input  logic [CNT_WIDTH-1:0] cfg_burst_len,
    input  logic [CNT_WIDTH-1:0] cfg_gap_len,
    input  logic [REP_WIDTH-1:0] cfg_repeat,
    input  logic                 dac_sync,
    input  logic                 dac_valid_in,
    input  logic                 dac_dunf,
    output logic                 dac_valid_i,
    output logic                 dac_valid_q,
    output logic                 dac_tx_en,
    output logic                 busy,
    output logic                 done,
    output logic                 unf_err,
    output logic [REP_WIDTH-1:0] burst_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] smp_cnt_q, smp_cnt_d;      // shared by RUN and GAP
    logic [CNT_WIDTH-1:0] burst_len_q, burst_len_d;
    logic [CNT_WIDTH-1:0] gap_len_q, gap_len_d;
    logic [REP_WIDTH-1:0] repeat_q, repeat_d;
    logic [REP_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
    logic                 done_q, done_d;
    logic                 unf_err_q, unf_err_d;
    logic                 tx_en_q, tx_en_d;

    logic [REP_WIDTH-1:0] burst_inc;
    logic                 burst_last_smp;
    logic                 gap_last_smp;
    logic                 final_burst;

    // burst_len_q is never 0 once latched. gap_last_smp is only used when
    // gap_len_q != 0. So the "-1" never has to wrap in a meaningful case.
    always_comb begin
        burst_inc      = burst_cnt_q + REP_WIDTH'(1);
        burst_last_smp = (smp_cnt_q == (burst_len_q - CNT_WIDTH'(1)));
        gap_last_smp   = (smp_cnt_q == (gap_len_q - CNT_WIDTH'(1)));
        final_burst    = (repeat_q != '0) && (burst_inc == repeat_q);
    end

    always_comb begin
        state_d     = state_q;
        smp_cnt_d   = smp_cnt_q;
        burst_len_d = burst_len_q;
        gap_len_d   = gap_len_q;
        repeat_d    = repeat_q;
        burst_cnt_d = burst_cnt_q;
        done_d      = 1'b0;
        // Underflow is sticky. A stop keeps it. Only an accepted start
        // (below) or reset clears it.
        unf_err_d   = unf_err_q | ((state_q == ST_RUN) && dac_dunf);

        if (cfg_stop) begin
            // Abort from any state. This also suppresses a done pulse that
            // a burst completing in this same cycle would have raised.
            state_d     = ST_IDLE;
            smp_cnt_d   = '0;
            burst_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start && (cfg_burst_len != '0)) begin
                        burst_len_d = cfg_burst_len;
                        gap_len_d   = cfg_gap_len;
                        repeat_d    = cfg_repeat;
                        burst_cnt_d = '0;
                        smp_cnt_d   = '0;
                        unf_err_d   = 1'b0;
                        state_d     = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (dac_sync) begin
                        smp_cnt_d = '0;
                        state_d   = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (dac_valid_in) begin
                        if (burst_last_smp) begin
                            smp_cnt_d   = '0;
                            // Wraps naturally when running with repeat 0.
                            burst_cnt_d = burst_inc;
                            if (final_burst) begin
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end else if (gap_len_q != '0) begin
                                state_d = ST_GAP;
                            end
                        end else begin
                            smp_cnt_d = smp_cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (dac_valid_in) begin
                        if (gap_last_smp) begin
                            smp_cnt_d = '0;
                            state_d   = ST_RUN;
                        end else begin
                            smp_cnt_d = smp_cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Registered alongside the state so that dac_tx_en tracks state_q.
        tx_en_d = (state_d == ST_RUN);
    end

    always_ff @(posedge dac_clk) begin
        if (dac_rst) begin
            state_q     <= ST_IDLE;
            smp_cnt_q   <= '0;
            burst_len_q <= '0;
            gap_len_q   <= '0;
            repeat_q    <= '0;
            burst_cnt_q <= '0;
            done_q      <= 1'b0;
            unf_err_q   <= 1'b0;
            tx_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            smp_cnt_q   <= smp_cnt_d;
            burst_len_q <= burst_len_d;
            gap_len_q   <= gap_len_d;
            repeat_q    <= repeat_d;
            burst_cnt_q <= burst_cnt_d;
            done_q      <= done_d;
            unf_err_q   <= unf_err_d;
            tx_en_q     <= tx_en_d;
        end
    end

    // The gated strobes are zero latency, so the DMA sees the same cycle's
    // strobe while in RUN.
    assign dac_valid_i = (state_q == ST_RUN) && dac_valid_in;
    assign dac_valid_q = (state_q == ST_RUN) && dac_valid_in;
    assign dac_tx_en   = tx_en_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign unf_err     = unf_err_q;
    assign burst_cnt   = burst_cnt_q;

endmodule

// File: tb/tb_axi_ad9963_tx_burst_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for axi_ad9963_tx_burst_ctrl.
//
// The stimulus pushes the expected gated-valid and done events into a queue.
// Each event carries its absolute cycle number and burst_cnt value. A monitor
// pops one event whenever the DUT shows dac_valid_i or done. It compares them
// at the falling edge. Spot checks of status outputs are made inline.
// -----------------------------------------------------------------------------
module tb_axi_ad9963_tx_burst_ctrl;

    localparam int CW = 16;
    localparam int RW = 8;

    logic          dac_clk;
    logic          dac_rst;
    logic          cfg_start;
    logic          cfg_stop;
    logic [CW-1:0] cfg_burst_len;
    logic [CW-1:0] cfg_gap_len;
    logic [RW-1:0] cfg_repeat;
    logic          dac_sync;
    logic          dac_valid_in;
    logic          dac_dunf;
    logic          dac_valid_i;
    logic          dac_valid_q;
    logic          dac_tx_en;
    logic          busy;
    logic          done;
    logic          unf_err;
    logic [RW-1:0] burst_cnt;

    axi_ad9963_tx_burst_ctrl #(.CNT_WIDTH(CW), .REP_WIDTH(RW)) dut (
        .dac_clk       (dac_clk),
        .dac_rst       (dac_rst),
        .cfg_start     (cfg_start),
        .cfg_stop      (cfg_stop),
        .cfg_burst_len (cfg_burst_len),
        .cfg_gap_len   (cfg_gap_len),
        .cfg_repeat    (cfg_repeat),
        .dac_sync      (dac_sync),
        .dac_valid_in  (dac_valid_in),
        .dac_dunf      (dac_dunf),
        .dac_valid_i   (dac_valid_i),
        .dac_valid_q   (dac_valid_q),
        .dac_tx_en     (dac_tx_en),
        .busy          (busy),
        .done          (done),
        .unf_err       (unf_err),
        .burst_cnt     (burst_cnt)
    );

    initial dac_clk = 1'b0;
    always #5 dac_clk = ~dac_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge dac_clk) cyc++;

    typedef struct {
        bit is_done;
        int cyc;
        int bcnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic push_v(input int c, input int b);
        exp_q.push_back('{is_done: 1'b0, cyc: c, bcnt: b});
    endtask

    task automatic push_d(input int c, input int b);
        exp_q.push_back('{is_done: 1'b1, cyc: c, bcnt: b});
    endtask

    // Monitor: every gated valid or done pulse must match the head of the queue.
    always @(negedge dac_clk) begin
        if (dac_valid_i === 1'b1 || done === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event cyc=%0d actual valid_i=%0b done=%0b burst_cnt=%0d required no event",
                         cyc, dac_valid_i, done, burst_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                if (done !== mon_e.is_done || dac_valid_i !== !mon_e.is_done ||
                    cyc != mon_e.cyc || burst_cnt !== RW'(mon_e.bcnt) ||
                    (!mon_e.is_done && (dac_valid_q !== 1'b1 || dac_tx_en !== 1'b1)) ||
                    (mon_e.is_done && (busy !== 1'b0 || dac_tx_en !== 1'b0))) begin
                    n_err++;
                    $display("FAIL event actual cyc=%0d done=%0b vi=%0b vq=%0b tx_en=%0b busy=%0b bcnt=%0d required cyc=%0d done=%0b bcnt=%0d",
                             cyc, done, dac_valid_i, dac_valid_q, dac_tx_en, busy, burst_cnt,
                             mon_e.cyc, mon_e.is_done, mon_e.bcnt);
                end else begin
                    $display("event cyc=%0d %s burst_cnt=%0d ok", cyc,
                             mon_e.is_done ? "done" : "valid", burst_cnt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge dac_clk);
        #1;
    endtask

    task automatic neg();
        @(negedge dac_clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic clr_in();
        cfg_start     = 1'b0;
        cfg_stop      = 1'b0;
        cfg_burst_len = '0;
        cfg_gap_len   = '0;
        cfg_repeat    = '0;
        dac_sync      = 1'b0;
        dac_valid_in  = 1'b0;
        dac_dunf      = 1'b0;
    endtask

    task automatic start_cfg(input int bl, input int gl, input int rp);
        cfg_burst_len = CW'(bl);
        cfg_gap_len   = CW'(gl);
        cfg_repeat    = RW'(rp);
        cfg_start     = 1'b1;
    endtask

    task automatic wait_drain(input string nm);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            tick();
            k++;
        end
        chk(nm, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    int s;

    initial begin
        clr_in();
        dac_rst = 1'b1;
        tick();
        dac_valid_in = 1'b1;
        repeat (2) tick();
        neg();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_unf", unf_err, 0);
        chk("rst_tx_en", dac_tx_en, 0);
        chk("rst_valid_i", dac_valid_i, 0);
        chk("rst_burst_cnt", burst_cnt, 0);
        tick();
        dac_rst = 1'b0;
        dac_valid_in = 1'b0;

        // Burst 4, gap 2, repeat 2, valid every cycle; cfg changed while busy.
        tick();
        s = cyc;
        start_cfg(4, 2, 2);
        dac_valid_in = 1'b1;
        for (int k = 2; k <= 5; k++) push_v(s + k, 0);
        for (int k = 8; k <= 11; k++) push_v(s + k, 1);
        push_d(s + 12, 2);
        tick();
        cfg_start = 1'b0;
        dac_sync = 1'b1;
        cfg_burst_len = CW'(7);
        cfg_gap_len = '0;
        cfg_repeat = RW'(5);
        neg();
        chk("t1_armed_busy", busy, 1);
        chk("t1_armed_tx_en", dac_tx_en, 0);
        tick();
        dac_sync = 1'b0;
        repeat (10) tick();
        neg();
        chk("t1_final_burst_cnt", burst_cnt, 2);
        chk("t1_final_busy", busy, 0);
        tick();
        neg();
        chk("t1_done_one_cycle", done, 0);
        wait_drain("t1_drain");

        // Burst 3, no gap, repeat 3, valid every other cycle.
        clr_in();
        tick();
        s = cyc;
        start_cfg(3, 0, 3);
        for (int b = 0; b < 3; b++)
            for (int j = 0; j < 3; j++)
                push_v(s + 2 + 6 * b + 2 * j, b);
        push_d(s + 19, 3);
        tick();
        cfg_start = 1'b0;
        dac_sync = 1'b1;
        for (int k = 2; k <= 19; k++) begin
            tick();
            dac_sync = 1'b0;
            dac_valid_in = ((k % 2) == 0);
        end
        neg();
        chk("t2_burst_cnt", burst_cnt, 3);
        wait_drain("t2_drain");

        // Infinite repeat, burst 2, gap 1; stop during the gap after 5 bursts.
        clr_in();
        tick();
        s = cyc;
        start_cfg(2, 1, 0);
        dac_valid_in = 1'b1;
        for (int b = 0; b < 5; b++) begin
            push_v(s + 2 + 3 * b, b);
            push_v(s + 3 + 3 * b, b);
        end
        tick();
        cfg_start = 1'b0;
        dac_sync = 1'b1;
        for (int k = 2; k <= 15; k++) begin
            tick();
            dac_sync = 1'b0;
        end
        tick();
        cfg_stop = 1'b1;
        neg();
        chk("t3_burst_cnt_5", burst_cnt, 5);
        chk("t3_gap_tx_en", dac_tx_en, 0);
        tick();
        cfg_stop = 1'b0;
        neg();
        chk("t3_stop_busy", busy, 0);
        chk("t3_stop_burst_cnt", burst_cnt, 0);
        chk("t3_stop_tx_en", dac_tx_en, 0);
        chk("t3_stop_valid_i", dac_valid_i, 0);
        repeat (3) tick();
        wait_drain("t3_drain");

        // Underflow: ignored in ARMED, sticky in RUN, kept through stop,
        // cleared by the next accepted start.
        clr_in();
        tick();
        s = cyc;
        start_cfg(4, 0, 0);
        dac_valid_in = 1'b1;
        for (int k = 2; k <= 5; k++) push_v(s + k, 0);
        tick();
        cfg_start = 1'b0;
        dac_sync = 1'b1;
        dac_dunf = 1'b1;
        tick();
        dac_sync = 1'b0;
        dac_dunf = 1'b0;
        neg();
        chk("t4_armed_dunf_ignored", unf_err, 0);
        tick();
        dac_dunf = 1'b1;
        tick();
        dac_dunf = 1'b0;
        neg();
        chk("t4_unf_set", unf_err, 1);
        tick();
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        neg();
        chk("t4_stop_busy", busy, 0);
        chk("t4_stop_unf_kept", unf_err, 1);
        chk("t4_stop_burst_cnt", burst_cnt, 0);
        tick();
        dac_valid_in = 1'b0;
        neg();
        chk("t4_idle_unf_kept", unf_err, 1);
        tick();
        start_cfg(4, 0, 0);
        tick();
        cfg_start = 1'b0;
        neg();
        chk("t4_restart_unf_clr", unf_err, 0);
        chk("t4_restart_busy", busy, 1);
        tick();
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        neg();
        chk("t4_final_busy", busy, 0);
        wait_drain("t4_drain");

        // Start together with stop stays idle; start with burst_len 0 is ignored.
        clr_in();
        tick();
        start_cfg(4, 2, 2);
        cfg_stop = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_stop = 1'b0;
        neg();
        chk("t5_start_stop_busy", busy, 0);
        tick();
        start_cfg(0, 2, 2);
        tick();
        cfg_start = 1'b0;
        neg();
        chk("t5_len0_busy", busy, 0);
        tick();
        dac_sync = 1'b1;
        dac_valid_in = 1'b1;
        tick();
        dac_sync = 1'b0;
        neg();
        chk("t5_sync_in_idle_busy", busy, 0);
        chk("t5_sync_in_idle_tx_en", dac_tx_en, 0);
        tick();
        wait_drain("t5_drain");

        // Reset mid-RUN, then a normal run.
        clr_in();
        tick();
        s = cyc;
        start_cfg(8, 0, 0);
        dac_valid_in = 1'b1;
        for (int k = 2; k <= 4; k++) push_v(s + k, 0);
        tick();
        cfg_start = 1'b0;
        dac_sync = 1'b1;
        tick();
        dac_sync = 1'b0;
        tick();
        dac_dunf = 1'b1;
        tick();
        dac_dunf = 1'b0;
        dac_rst = 1'b1;
        neg();
        chk("t6_pre_rst_unf", unf_err, 1);
        tick();
        dac_rst = 1'b0;
        neg();
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_tx_en", dac_tx_en, 0);
        chk("t6_rst_valid_i", dac_valid_i, 0);
        chk("t6_rst_valid_q", dac_valid_q, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_burst_cnt", burst_cnt, 0);
        chk("t6_rst_unf", unf_err, 0);
        tick();
        s = cyc;
        start_cfg(2, 0, 1);
        push_v(s + 2, 0);
        push_v(s + 3, 0);
        push_d(s + 4, 1);
        tick();
        cfg_start = 1'b0;
        dac_sync = 1'b1;
        tick();
        dac_sync = 1'b0;
        tick();
        tick();
        neg();
        chk("t6_rerun_busy", busy, 0);
        chk("t6_rerun_burst_cnt", burst_cnt, 1);
        wait_drain("t6_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
